mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words; it must be a power of two, at least 2.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra wait cycles between capture and response; 0 is legal.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mem_read  input  1  one-cycle read request pulse from the initiator.
REQ-006 mem_write  input  1  one-cycle write request pulse from the initiator.
REQ-007 addr  input  32  byte address; SHALL be stable from request cycle +1 until mem_resp.
REQ-008 wdata  input  32  store data; same stability window as addr.
REQ-009 mem_resp  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  read data, registered.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err_misaligned  output  1  sticky flag: a captured addr[1:0] was nonzero.
REQ-013 err_protocol  output  1  sticky flag: an illegal request was seen.

Function
REQ-014 The FSM SHALL have four states: IDLE, CAPTURE, WAIT and RESP.
REQ-015 In IDLE, mem_read or mem_write high SHALL cause the next state to be CAPTURE, and the operation type SHALL be latched.
REQ-016 In CAPTURE, addr and wdata SHALL be registered, because the initiator's address register updates one cycle after the request pulse.
REQ-017 From CAPTURE, the FSM SHALL go to RESP if WAIT_CYCLES=0; otherwise it SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle the counter equals 0.
REQ-019 In RESP, mem_resp SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 Latency: a request at cycle T SHALL give mem_resp at cycle T+2+WAIT_CYCLES.
REQ-021 Read: rdata SHALL be loaded with mem[word index] on the edge entering RESP.
REQ-022 rdata SHALL be valid during the mem_resp cycle and held unchanged until the next read completes.
REQ-023 Write: mem[word index] SHALL be written with the captured wdata on the edge entering RESP.
REQ-024 A write SHALL leave rdata unchanged.
REQ-025 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses alias and wrap.
REQ-026 A misaligned address SHALL set err_misaligned and still produce a response.
REQ-027 A misaligned read SHALL return rdata=0; a misaligned write SHALL be dropped.
REQ-028 If mem_read and mem_write are high in the same IDLE cycle, err_protocol SHALL be set and the write SHALL be serviced.
REQ-029 A request pulse in any state other than IDLE SHALL be ignored and SHALL set err_protocol.
REQ-030 The error flags SHALL be sticky and SHALL clear only on reset.
REQ-031 A request at the cycle IDLE is re-entered (RESP+1) SHALL be accepted normally.

Reset
REQ-032 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, mem_resp=0, rdata=0, busy=0, err_misaligned=0, err_protocol=0 and counter=0.
REQ-033 Reset mid-operation SHALL abort the transaction: no response is issued, and a pending write SHALL not be committed.
REQ-034 Storage contents SHALL not be cleared by reset.

Structure
REQ-035 The state enum type mem_resp_state_t SHALL be placed in the shared datatypes package, next to the existing control and mux-select types.
REQ-036 The storage SHALL be one sub-module, sp_ram: a single-port synchronous RAM, 32-bit words, DEPTH_WORDS deep, with we, idx, wdata and rdata ports.
REQ-037 The FSM, counter, capture registers and flags SHALL reside in mem_responder.

Verification
REQ-038 The bench SHALL cover: WAIT_CYCLES=2; write pulse with addr=0x10, wdata=0xDEADBEEF at T -> mem_resp at T+4; then read 0x10 -> rdata=0xDEADBEEF at its resp cycle and held until the next read.
REQ-039 The bench SHALL cover: WAIT_CYCLES=0; read pulse at T -> mem_resp at T+2, busy high during T+1..T+2.
REQ-040 The bench SHALL cover: DEPTH_WORDS=1024; write 0x11111111 to 0x0000_0004, then read 0x0000_1004 -> rdata=0x11111111 (aliasing).
REQ-041 The bench SHALL cover: read at addr=0x13 -> err_misaligned=1, rdata=0, mem_resp still issued; a following write to 0x12 leaves word 4 unchanged.
REQ-042 The bench SHALL cover: second mem_read pulse during WAIT -> err_protocol=1 and exactly one mem_resp; mem_read and mem_write together -> err_protocol=1 and the write is committed.
REQ-043 The bench SHALL cover: rst_n=0 during WAIT of a write to 0x20 (prior contents 0xA5A5A5A5) -> no mem_resp, busy=0 next cycle, and a read of 0x20 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared datatypes for the memory responder slice.
//   mem_resp_state_t : responder FSM states
//   mem_op_t         : latched operation type (control)
//   rdata_sel_t      : source select for the rdata output mux
//   is_aligned()     : true when a byte address is word aligned
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESP    = 2'd3
    } mem_resp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        RSEL_HOLD = 2'd0,
        RSEL_RAM  = 2'd1,
        RSEL_ZERO = 2'd2
    } rdata_sel_t;

    function automatic logic is_aligned(input logic [1:0] i_lsb);
        return (i_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous RAM, 32-bit words.
// Write and read share one index; the read port is registered and is
// read-first, so rdata shows the word as it was before a same-edge write.
// Contents are never reset.
//   clk   : clock
//   we    : write enable, commits wdata to mem[idx] on the rising edge
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, mem[idx] sampled on the previous edge
module sp_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        r_rdata <= r_mem[idx];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one-cycle read/write pulses, captures the
// address/data one cycle later, waits WAIT_CYCLES and answers with a
// one-cycle mem_resp. DEPTH_WORDS must be a power of two, at least 2.
//   clk, rst_n      : clock, synchronous active-low reset
//   mem_read        : read request pulse
//   mem_write       : write request pulse (wins if both are high)
//   addr, wdata     : byte address / store data, stable from request+1
//   mem_resp        : one-cycle completion pulse
//   rdata           : read data, valid in the mem_resp cycle, held after
//   busy            : high whenever the FSM is not idle
//   err_misaligned  : sticky, a captured address had addr[1:0] != 0
//   err_protocol    : sticky, illegal request (both pulses, or while busy)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_resp,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err_misaligned,
    output logic        err_protocol
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_resp_state_t  r_state;
    mem_resp_state_t  w_next;
    mem_op_t          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata_hold;
    logic             r_err_mis;
    logic             r_err_prot;

    logic             w_req;
    logic             w_enter_resp;
    logic [IDX_W+1:0] w_addr_cur;
    logic [31:0]      w_wdata_cur;
    logic             w_aligned;
    logic             w_ram_we;
    logic [IDX_W-1:0] w_ram_idx;
    logic [31:0]      w_ram_rdata;
    rdata_sel_t       w_rsel;

    assign w_req = mem_read | mem_write;

    // With WAIT_CYCLES=0 the RAM access happens on the same edge that loads
    // the capture registers, so during CAPTURE the live bus is used directly.
    assign w_addr_cur  = (r_state == ST_CAPTURE) ? addr[IDX_W+1:0] : r_addr;
    assign w_wdata_cur = (r_state == ST_CAPTURE) ? wdata : r_wdata;
    assign w_aligned   = is_aligned(w_addr_cur[1:0]);
    assign w_ram_idx   = w_addr_cur[IDX_W+1:2];

    // Gated by rst_n so a reset on the committing edge drops the write.
    assign w_enter_resp = rst_n && (r_state != ST_RESP) && (w_next == ST_RESP);
    assign w_ram_we     = w_enter_resp && (r_op == OP_WRITE) && w_aligned;

    sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .idx   (w_ram_idx),
        .wdata (w_wdata_cur),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_req) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT:    if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        mem_resp = (r_state == ST_RESP);
        w_rsel   = RSEL_HOLD;
        if ((r_state == ST_RESP) && (r_op == OP_READ)) begin
            w_rsel = is_aligned(r_addr[1:0]) ? RSEL_RAM : RSEL_ZERO;
        end
    end

    // The RAM output register is the value loaded on the edge entering
    // RESP; afterwards the holding register keeps it until the next read.
    always_comb begin
        case (w_rsel)
            RSEL_RAM:  rdata = w_ram_rdata;
            RSEL_ZERO: rdata = '0;
            default:   rdata = r_rdata_hold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CAPTURE) begin
            r_addr  <= addr[IDX_W+1:0];
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= OP_READ;
            r_cnt        <= '0;
            r_err_mis    <= 1'b0;
            r_err_prot   <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_op <= mem_write ? OP_WRITE : OP_READ;
            end
            if (r_state == ST_CAPTURE) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if ((r_state == ST_CAPTURE) && !is_aligned(addr[1:0])) begin
                r_err_mis <= 1'b1;
            end
            if (w_req && ((r_state != ST_IDLE) || (mem_read && mem_write))) begin
                r_err_prot <= 1'b1;
            end
            if ((r_state == ST_RESP) && (r_op == OP_READ)) begin
                r_rdata_hold <= rdata;
            end
        end
    end

    assign err_misaligned = r_err_mis;
    assign err_protocol   = r_err_prot;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] addr_i [2];
    logic [31:0] wd_i   [2];
    logic        resp_o [2];
    logic        busy_o [2];
    logic        mis_o  [2];
    logic        prot_o [2];
    logic [31:0] rdata_o[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // dut index 0: WAIT_CYCLES=2, dut index 1: WAIT_CYCLES=0
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
        .addr(addr_i[0]), .wdata(wd_i[0]), .mem_resp(resp_o[0]),
        .rdata(rdata_o[0]), .busy(busy_o[0]), .err_misaligned(mis_o[0]),
        .err_protocol(prot_o[0])
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
        .addr(addr_i[1]), .wdata(wd_i[1]), .mem_resp(resp_o[1]),
        .rdata(rdata_o[1]), .busy(busy_o[1]), .err_misaligned(mis_o[1]),
        .err_protocol(prot_o[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", nm, d, act, exp);
        end
    endtask

    // Transaction-level model: each accepted request is remembered with its
    // start cycle; busy/resp windows follow from the latency rule and the
    // memory effect is applied in the response cycle.
    bit          pend  [2];
    int          t0m   [2];
    bit          m_wr  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_wd  [2];
    logic [31:0] m_rd  [2];
    bit          m_rdk [2];
    bit          m_mis [2];
    bit          m_prot[2];
    logic [31:0] mm    [2][1024];
    bit          mk    [2][1024];

    initial begin : model
        bit eb;
        bit er;
        int w;
        int ix;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; t0m[d] = 0; m_wr[d] = 1'b0;
            m_a[d] = '0; m_wd[d] = '0; m_rd[d] = '0; m_rdk[d] = 1'b1;
            m_mis[d] = 1'b0; m_prot[d] = 1'b0;
            for (int i = 0; i < 1024; i++) mk[d][i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    w  = (d == 0) ? 2 : 0;
                    eb = pend[d] && (cyc >= t0m[d] + 1) && (cyc <= t0m[d] + 2 + w);
                    er = pend[d] && (cyc == t0m[d] + 2 + w);
                    ix = int'(m_a[d][11:2]);
                    if (er) begin
                        if (m_a[d][1:0] != 2'b00) begin
                            if (!m_wr[d]) begin
                                m_rd[d] = '0; m_rdk[d] = 1'b1;
                            end
                        end else if (m_wr[d]) begin
                            mm[d][ix] = m_wd[d]; mk[d][ix] = 1'b1;
                        end else begin
                            m_rd[d] = mm[d][ix]; m_rdk[d] = mk[d][ix];
                        end
                    end
                    chk("mem_resp", d, 32'(resp_o[d]), 32'(er));
                    chk("busy", d, 32'(busy_o[d]), 32'(eb));
                    chk("err_misaligned", d, 32'(mis_o[d]), 32'(m_mis[d]));
                    chk("err_protocol", d, 32'(prot_o[d]), 32'(m_prot[d]));
                    if (m_rdk[d]) chk("rdata", d, rdata_o[d], m_rd[d]);

                    if (er) pend[d] = 1'b0;
                    if (pend[d] && (cyc == t0m[d] + 1)) begin
                        m_a[d]  = addr_i[d];
                        m_wd[d] = wd_i[d];
                        if (addr_i[d][1:0] != 2'b00) m_mis[d] = 1'b1;
                    end
                    if (!rst_n) begin
                        pend[d] = 1'b0; m_mis[d] = 1'b0; m_prot[d] = 1'b0;
                        m_rd[d] = '0; m_rdk[d] = 1'b1;
                    end else if (rd_i[d] || wr_i[d]) begin
                        if (!eb) begin
                            pend[d] = 1'b1;
                            t0m[d]  = cyc;
                            m_wr[d] = wr_i[d];
                            if (rd_i[d] && wr_i[d]) m_prot[d] = 1'b1;
                        end else begin
                            m_prot[d] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd);
        rd_i[d]   = rd;
        wr_i[d]   = wr;
        addr_i[d] = a;
        wd_i[d]   = wd;
    endtask

    // Issues a request in the current cycle, optionally a stray read pulse
    // extra_at cycles later, and returns the observed response latency
    // (-1 if none). Returns in the cycle after the response.
    task automatic do_req(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int extra_at, output int lat);
        int t0;
        t0  = cyc;
        lat = -1;
        set_in(d, rd, wr, a, wd);
        for (int k = 0; (k < 16) && (lat < 0); k++) begin
            tick();
            set_in(d, (cyc - t0) == extra_at, 1'b0, a, wd);
            @(negedge clk);
            if (resp_o[d]) lat = cyc - t0;
        end
        tick();
        set_in(d, 1'b0, 1'b0, a, wd);
    endtask

    initial begin : driver
        int lat;
        bit seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) set_in(d, 1'b0, 1'b0, '0, '0);
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;

        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_rdata", 0, rdata_o[0], 32'h0);
        chk("rst_err_mis", 0, 32'(mis_o[0]), 32'd0);
        chk("rst_err_prot", 0, 32'(prot_o[0]), 32'd0);
        chk("rst_resp", 1, 32'(resp_o[1]), 32'd0);

        // write then read back, WAIT_CYCLES=2
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, lat);
        chk("w2_write_latency", 0, lat, 32'd4);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, -1, lat);
        chk("w2_read_latency", 0, lat, 32'd4);
        chk("w2_read_data", 0, rdata_o[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, 32'h14, 32'h55555555, -1, lat);
        chk("w2_rdata_held_over_write", 0, rdata_o[0], 32'hDEADBEEF);

        // WAIT_CYCLES=0
        do_req(1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, -1, lat);
        chk("w0_write_latency", 1, lat, 32'd2);
        do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, -1, lat);
        chk("w0_read_latency", 1, lat, 32'd2);
        chk("w0_read_data", 1, rdata_o[1], 32'h0BADF00D);

        // aliasing of upper address bits
        do_req(0, 1'b0, 1'b1, 32'h0000_0004, 32'h11111111, -1, lat);
        do_req(0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, -1, lat);
        chk("alias_read_data", 0, rdata_o[0], 32'h11111111);

        // misaligned read, then misaligned write must not touch word 4
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, -1, lat);
        chk("misaligned_read_latency", 0, lat, 32'd4);
        chk("misaligned_read_flag", 0, 32'(mis_o[0]), 32'd1);
        chk("misaligned_read_data", 0, rdata_o[0], 32'h0);
        do_req(0, 1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, -1, lat);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, -1, lat);
        chk("misaligned_write_dropped", 0, rdata_o[0], 32'hDEADBEEF);

        // stray read pulse during WAIT
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("flags_clear_prot", 0, 32'(prot_o[0]), 32'd0);
        chk("flags_clear_mis", 0, 32'(mis_o[0]), 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 2, lat);
        chk("stray_pulse_latency", 0, lat, 32'd4);
        chk("stray_pulse_prot", 0, 32'(prot_o[0]), 32'd1);

        // simultaneous read+write: write wins
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        do_req(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, -1, lat);
        chk("both_pulses_prot", 0, 32'(prot_o[0]), 32'd1);
        chk("both_pulses_latency", 0, lat, 32'd4);
        do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, -1, lat);
        chk("both_pulses_write_committed", 0, rdata_o[0], 32'hCAFEF00D);

        // reset during WAIT aborts a pending write
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, -1, lat);
        set_in(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        tick();
        set_in(0, 1'b0, 1'b0, 32'h20, 32'h12345678);
        tick();
        chk("abort_busy_before_reset", 0, 32'(busy_o[0]), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("abort_busy_after_reset", 0, 32'(busy_o[0]), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_o[0]) seen = 1'b1;
        end
        chk("abort_no_resp", 0, 32'(seen), 32'd0);
        tick();
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, -1, lat);
        chk("abort_write_not_committed", 0, rdata_o[0], 32'hA5A5A5A5);

        // WAIT_CYCLES=0: misaligned write dropped, storage survives reset, wrap
        do_req(1, 1'b0, 1'b1, 32'h41, 32'h77777777, -1, lat);
        chk("w0_misaligned_flag", 1, 32'(mis_o[1]), 32'd1);
        chk("w0_misaligned_latency", 1, lat, 32'd2);
        do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, -1, lat);
        chk("w0_storage_kept", 1, rdata_o[1], 32'h0BADF00D);
        do_req(1, 1'b0, 1'b1, 32'h0000_0FFC, 32'h600DCAFE, -1, lat);
        do_req(1, 1'b1, 1'b0, 32'hFFFF_7FFC, 32'h0, -1, lat);
        chk("w0_alias_top_word", 1, rdata_o[1], 32'h600DCAFE);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
